hamming_tx: RTL and testbench

Upstream stage of the Hamming(12,8) link: accepts 8-bit payload bytes over a valid/ready handshake and buffers them in a 4-entry FIFO. It encodes each byte into an even-parity Hamming(12,8) codeword and presents it on a registered 12-bit output that feeds the `data` input of the decode/ALU stage. It also keeps a running count of delivered codewords for link bookkeeping.

---
 rtl/hamming_tx.sv | 139 +++++++++++++
 tb/tb_hamming_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_tx.sv
// hamming_tx: upstream stage of the Hamming(12,8) link.
// Buffers payload bytes in a DEPTH-entry FIFO and encodes each one into an
// even-parity Hamming(12,8) codeword held in a registered output stage.
// Keeps a modulo-256 count of delivered codewords.
// Optional feature: define HAM_ERR_INJECT_EN to add the inj_en/inj_pos
// single-bit error injection ports.
module hamming_tx #(
  parameter int DEPTH = 4,
  parameter int CW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    sent_cnt
`ifdef HAM_ERR_INJECT_EN
  ,
  input  logic          inj_en,
  input  logic [3:0]    inj_pos
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        deliver;
  logic [11:0] inj_mask;
  logic [11:0] load_word;

  // Even-parity Hamming(12,8): parity at positions 1,2,4,8, data in the rest.
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c;
    c      = '0;
    c[2]   = d[0];
    c[4]   = d[1];
    c[5]   = d[2];
    c[6]   = d[3];
    c[8]   = d[4];
    c[9]   = d[5];
    c[10]  = d[6];
    c[11]  = d[7];
    c[0]   = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1]   = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3]   = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7]   = c[8] ^ c[9] ^ c[10] ^ c[11];
    return c;
  endfunction

  // Extra pointer bit separates a wrapped (full) FIFO from an empty one.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // in_ready looks only at FIFO state, so out_ready never reaches it combinationally.
  assign in_ready  = !fifo_full;
  assign out_valid = (state == FULL);
  assign push      = in_valid && !fifo_full;
  assign deliver   = (state == FULL) && out_ready;
  assign pop       = !fifo_empty && ((state == EMPTY) || out_ready);

`ifdef HAM_ERR_INJECT_EN
  // Single-bit flip mask; positions outside 1..12 leave the codeword clean.
  always_comb begin
    inj_mask = '0;
    if (inj_en && (inj_pos >= 4'd1) && (inj_pos <= 4'd12)) begin
      inj_mask[inj_pos - 4'd1] = 1'b1;
    end
  end
`else
  assign inj_mask = '0;
`endif

  assign load_word = encode(mem[rd_ptr[AW-1:0]]) ^ inj_mask;

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // FIFO pointers advance on accept and on load into the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= next_state;
  end

  // Output stage next state: fill when data waits, drain when consumed with nothing behind.
  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (!fifo_empty) next_state = FULL;
      FULL:    if (out_ready && fifo_empty) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

  // Codeword register loads on every pop and otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     data <= '0;
    else if (pop) data <= load_word;
  end

  // Delivered-codeword counter, wraps naturally at 256.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         sent_cnt <= '0;
    else if (deliver) sent_cnt <= sent_cnt + 8'd1;
  end

endmodule

// File: tb/tb_hamming_tx.sv
// tb_hamming_tx: randomized self-checking bench for hamming_tx against a
// queue-based transaction model with a loop-built Hamming reference encoder.
// Define HAM_ERR_INJECT_EN to also exercise error injection.
module tb_hamming_tx;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  sent_cnt;
`ifdef HAM_ERR_INJECT_EN
  logic        inj_en;
  logic [3:0]  inj_pos;
`endif

  int n_cmp;
  int n_fail;

  logic [7:0]  fifo_q[$];
  logic        m_valid;
  logic [11:0] m_data;
  int          m_cnt;

  hamming_tx #(.DEPTH(DEPTH), .CW(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sent_cnt  (sent_cnt)
`ifdef HAM_ERR_INJECT_EN
    ,
    .inj_en    (inj_en),
    .inj_pos   (inj_pos)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder: data bits fill non-power-of-two positions in order,
  // each parity bit at 2^k makes even the positions whose index has bit k set.
  function automatic logic [11:0] ref_encode(input logic [7:0] b, input bit en, input int pos);
    logic [11:0] cw;
    int k;
    bit par;
    cw = '0;
    k  = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = b[k];
        k++;
      end
    end
    for (int pp = 1; pp <= 8; pp = pp * 2) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++) begin
        if (p != pp && (p & pp) != 0) par = par ^ cw[p-1];
      end
      cw[pp-1] = par;
    end
    if (en && pos >= 1 && pos <= 12) cw[pos-1] = ~cw[pos-1];
    return cw;
  endfunction

  // Advance one clock edge and update the transaction model.
  task automatic tick();
    bit   in_fire;
    bit   out_fire;
    bit   do_pop;
    bit   en;
    int   pos;
    logic [7:0] b;
    en  = 1'b0;
    pos = 0;
`ifdef HAM_ERR_INJECT_EN
    en  = inj_en;
    pos = int'(inj_pos);
`endif
    in_fire  = in_valid && (fifo_q.size() < DEPTH);
    out_fire = m_valid && out_ready;
    do_pop   = (fifo_q.size() > 0) && (!m_valid || out_ready);
    b        = in_data;
    @(posedge clk);
    #1;
    if (out_fire) m_cnt++;
    if (do_pop) begin
      m_data  = ref_encode(fifo_q.pop_front(), en, pos);
      m_valid = 1'b1;
    end else if (out_fire) begin
      m_valid = 1'b0;
    end
    if (in_fire) fifo_q.push_back(b);
  endtask

  task automatic applyStimulus_reset();
    rst = 1'b0;
    #1;
    fifo_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_cnt   = 0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (data !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 000", data); end
    n_cmp++;
    if (sent_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_sent_cnt: got %0d expected 0", sent_cnt); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [7:0]  vin [4];
    logic [11:0] vexp [4];
    vin  = '{8'h00, 8'h01, 8'h80, 8'hFF};
    vexp = '{12'h000, 12'h007, 12'h888, 12'hF77};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_data  = (i < 4) ? vin[i] : 8'h00;
      tick();
      if (i == 0) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL vec_latency: out_valid got %b expected 0", out_valid); end
      end else if (i <= 4) begin
        n_cmp++;
        if (out_valid !== 1'b1 || data !== vexp[i-1]) begin
          n_fail++;
          $display("[TB] FAIL vec_%0d: got valid=%b data=%h expected valid=1 data=%h", i - 1, out_valid, data, vexp[i-1]);
        end
        n_cmp++;
        if (data !== m_data) begin n_fail++; $display("[TB] FAIL vec_model_%0d: got %h expected %h", i - 1, data, m_data); end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL vec_tail: out_valid got %b expected 0", out_valid); end
      end
    end
    n_cmp++;
    if (sent_cnt !== 8'(m_cnt)) begin n_fail++; $display("[TB] FAIL vec_sent_cnt: got %0d expected %0d", sent_cnt, m_cnt); end
  endtask

  task automatic test_backpressure();
    logic [11:0] held;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full: in_ready got %b expected 0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b1 || data !== m_data) begin
      n_fail++;
      $display("[TB] FAIL bp_head: got valid=%b data=%h expected valid=1 data=%h", out_valid, data, m_data);
    end
    held     = m_data;
    in_data  = 8'($urandom);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (data !== held || in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_hold: got data=%h in_ready=%b expected data=%h in_ready=0", data, in_ready, held);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [11:0] exp_q[$];
    int start_cnt;
    start_cnt = m_cnt;
    exp_q.push_back(m_data);
    foreach (fifo_q[i]) exp_q.push_back(ref_encode(fifo_q[i], 1'b0, 0));
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || data !== exp_q[i]) begin
        n_fail++;
        $display("[TB] FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, data, exp_q[i]);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_end: out_valid got %b expected 0", out_valid); end
    n_cmp++;
    if (sent_cnt !== 8'(start_cnt + 5)) begin n_fail++; $display("[TB] FAIL drain_cnt: got %0d expected %0d", sent_cnt, 8'(start_cnt + 5)); end
  endtask

  task automatic test_midstream_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 8'hA5 : 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    fifo_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_cnt   = 0;
    test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_discard: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      n_cmp++;
      if (in_ready !== (fifo_q.size() < DEPTH) || out_valid !== m_valid || sent_cnt !== 8'(m_cnt) ||
          (m_valid && data !== m_data)) begin
        n_fail++;
        $display("[TB] FAIL random_%0d: got rdy=%b vld=%b data=%h cnt=%0d expected rdy=%b vld=%b data=%h cnt=%0d",
                 i, in_ready, out_valid, data, sent_cnt, (fifo_q.size() < DEPTH), m_valid, m_data, 8'(m_cnt));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
  endtask

  task automatic test_counter_wrap();
    int pushed;
    int budget;
    applyStimulus_reset();
    pushed    = 0;
    budget    = 0;
    out_ready = 1'b1;
    while (pushed < 260 && budget < 600) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      if (fifo_q.size() < DEPTH) pushed++;
      tick();
      budget++;
    end
    in_valid = 1'b0;
    while (m_cnt < 260 && budget < 600) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (budget >= 600) begin n_fail++; $display("[TB] FAIL wrap_timeout: got %0d cycles expected under 600", budget); end
    n_cmp++;
    if (sent_cnt !== 8'd4) begin n_fail++; $display("[TB] FAIL wrap_cnt: got %0d expected 4", sent_cnt); end
  endtask

`ifdef HAM_ERR_INJECT_EN
  task automatic test_inject();
    applyStimulus_reset();
    out_ready = 1'b0;
    inj_en    = 1'b1;
    inj_pos   = 4'd5;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    tick();
    in_valid  = 1'b0;
    tick();
    inj_pos   = 4'd2;
    tick();
    n_cmp++;
    if (data !== 12'h010) begin n_fail++; $display("[TB] FAIL inj_pos5: got %h expected 010", data); end
    out_ready = 1'b1;
    inj_pos   = 4'd13;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    tick();
    in_valid  = 1'b0;
    tick();
    n_cmp++;
    if (data !== 12'h000) begin n_fail++; $display("[TB] FAIL inj_pos13: got %h expected 000", data); end
    for (int i = 0; i < 40; i++) begin
      inj_en    = ($urandom_range(0, 1) == 1);
      inj_pos   = 4'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++;
      if (out_valid !== m_valid || (m_valid && data !== m_data)) begin
        n_fail++;
        $display("[TB] FAIL inj_random_%0d: got vld=%b data=%h expected vld=%b data=%h", i, out_valid, data, m_valid, m_data);
      end
    end
    inj_en   = 1'b0;
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef HAM_ERR_INJECT_EN
    inj_en    = 1'b0;
    inj_pos   = '0;
`endif
    fifo_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_cnt   = 0;
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_vectors();
    test_backpressure();
    test_drain();
    test_midstream_reset();
    test_random();
    test_counter_wrap();
`ifdef HAM_ERR_INJECT_EN
    test_inject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
